// File: rtl/alu_pkg.sv
// Shared definitions for the ALU instruction issue path: instruction field
// positions, type-A function codes, issue FSM encoding and a legality helper.
package alu_pkg;

    localparam int INSTR_W = 16;

    // Instruction field positions: [15:12] opcode, [11:8] op1, [7:4] op2, [3:0] funct
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 12;
    localparam int OP1_MSB   = 11;
    localparam int OP1_LSB   = 8;
    localparam int OP2_MSB   = 7;
    localparam int OP2_LSB   = 4;
    localparam int FUNCT_MSB = 3;
    localparam int FUNCT_LSB = 0;

    localparam logic [3:0] OP_TYPEA = 4'b0000;

    localparam logic [3:0] FN_ADD = 4'b1111;
    localparam logic [3:0] FN_SUB = 4'b1110;
    localparam logic [3:0] FN_AND = 4'b1101;
    localparam logic [3:0] FN_OR  = 4'b1100;
    localparam logic [3:0] FN_MUL = 4'b0001;
    localparam logic [3:0] FN_DIV = 4'b0010;
    localparam logic [3:0] FN_SLL = 4'b1010;
    localparam logic [3:0] FN_SRL = 4'b1011;
    localparam logic [3:0] FN_ROL = 4'b1000;
    localparam logic [3:0] FN_ROR = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Non-type-A opcodes are always legal; type-A words need a defined funct.
    function automatic logic is_legal(input logic [INSTR_W-1:0] instr);
        logic ok;
        if (instr[OPC_MSB:OPC_LSB] != OP_TYPEA) begin
            ok = 1'b1;
        end else begin
            case (instr[FUNCT_MSB:FUNCT_LSB])
                FN_ADD, FN_SUB, FN_AND, FN_OR,
                FN_MUL, FN_DIV, FN_SLL, FN_SRL,
                FN_ROL, FN_ROR: ok = 1'b1;
                default:        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous instruction FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart by the MSB alone. A push while full is
// accepted when a pop happens on the same edge.
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [INSTR_W-1:0] wdata,
    output logic [INSTR_W-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem_r [DEPTH];
    logic [AW:0]        wptr_r;
    logic [AW:0]        rptr_r;
    logic               do_push_s;
    logic               do_pop_s;

    assign empty     = (wptr_r == rptr_r);
    assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = mem_r[rptr_r[AW-1:0]];

    // Storage array write; contents need no reset since empty guards reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wptr_r[AW-1:0]] <= wdata;
        end
    end

    // Read/write pointer advance, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU instruction issuer: buffers words, drives one at a time to the ALU,
// holds it for the function's latency, then captures the result together
// with its instruction and offers it downstream over valid/ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int BASIC_LAT = 1,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic [INSTR_W-1:0] alu_instr,
    input  logic [INSTR_W-1:0] alu_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [INSTR_W-1:0] res_data,
    output logic [INSTR_W-1:0] res_instr,
    output logic               busy,
    output logic               illegal
);

    localparam int MAX_LAT_0 = (BASIC_LAT > MUL_LAT) ? BASIC_LAT : MUL_LAT;
    localparam int MAX_LAT   = (MAX_LAT_0 > DIV_LAT) ? MAX_LAT_0 : DIV_LAT;
    localparam int CNT_W     = $clog2(MAX_LAT + 1);

    logic [INSTR_W-1:0] head_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic [CNT_W-1:0]   lat_s;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [INSTR_W-1:0] alu_instr_r;
    logic [INSTR_W-1:0] res_data_r;
    logic [INSTR_W-1:0] res_instr_r;
    logic               res_valid_r;
    logic               illegal_r;

    // The FSM consumes the head only from IDLE; that pop frees a slot the
    // same cycle, so a full FIFO still accepts a word on a popping edge.
    assign pop_s    = (state_r == IDLE) && !empty_s;
    assign in_ready = !full_s || pop_s;
    assign push_s   = in_valid && in_ready;

    alu_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (in_instr),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Hold latency of the head word, selected by its opcode and funct.
    always_comb begin
        lat_s = CNT_W'(BASIC_LAT);
        if (head_s[OPC_MSB:OPC_LSB] == OP_TYPEA) begin
            case (head_s[FUNCT_MSB:FUNCT_LSB])
                FN_MUL:  lat_s = CNT_W'(MUL_LAT);
                FN_DIV:  lat_s = CNT_W'(DIV_LAT);
                default: lat_s = CNT_W'(BASIC_LAT);
            endcase
        end else begin
            lat_s = CNT_W'(BASIC_LAT);
        end
    end

    // Issue FSM: pop/issue, count down the latency, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            alu_instr_r <= 16'h0000;
            res_data_r  <= 16'h0000;
            res_instr_r <= 16'h0000;
            res_valid_r <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            illegal_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!empty_s) begin
                        if (!is_legal(head_s)) begin
                            illegal_r <= 1'b1;
                        end else begin
                            alu_instr_r <= head_s;
                            cnt_r       <= lat_s;
                            state_r     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_r == CNT_W'(1)) begin
                        res_data_r  <= alu_result;
                        res_instr_r <= alu_instr_r;
                        res_valid_r <= 1'b1;
                        alu_instr_r <= 16'h0000;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    alu_instr_r <= 16'h0000;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign alu_instr = alu_instr_r;
    assign res_data  = res_data_r;
    assign res_instr = res_instr_r;
    assign res_valid = res_valid_r;
    assign illegal   = illegal_r;
    assign busy      = !empty_s || (state_r != IDLE);

endmodule
